// File: rtl/div_nonrestoring_pkg.sv
// Shared constants for the iterative signed divider: widths, FSM encodings and the overflow dividend.
// No timing or flow control of its own; consumed by div_addsub and div_nonrestoring.
package div_nonrestoring_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_CORR = 3'd3;
  localparam logic [2:0] ST_SIGN = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

endpackage

// File: rtl/div_addsub.sv
// (W+1)-bit add/subtract on a W-bit 4-bit-group carry-lookahead core; subtract inverts b with carry-in 1.
// Purely combinational, zero latency, no flow control.
module div_addsub
  import div_nonrestoring_pkg::*;
#(
  parameter int W = DIV_WIDTH
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  input  logic       sub,
  output logic [W:0] sum
);

  logic [W-1:0] bx;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         gg;
  logic         pg;
  int           base;

  always_comb begin
    bx   = sub ? ~b[W-1:0] : b[W-1:0];
    g    = a[W-1:0] & bx;
    p    = a[W-1:0] ^ bx;
    c    = '0;
    c[0] = sub;
    gg   = 1'b0;
    pg   = 1'b0;
    base = 0;
    // Full lookahead inside each nibble, group generate/propagate between nibbles.
    for (int k = 0; k < W / 4; k++) begin
      base = 4 * k;
      c[base+1] = g[base] | (p[base] & c[base]);
      c[base+2] = g[base+1] | (p[base+1] & g[base]) | (p[base+1] & p[base] & c[base]);
      c[base+3] = g[base+2] | (p[base+2] & g[base+1]) | (p[base+2] & p[base+1] & g[base])
                | (p[base+2] & p[base+1] & p[base] & c[base]);
      gg = g[base+3] | (p[base+3] & g[base+2]) | (p[base+3] & p[base+2] & g[base+1])
         | (p[base+3] & p[base+2] & p[base+1] & g[base]);
      pg = &p[base+:4];
      c[base+4] = gg | (pg & c[base]);
    end
    sum[W-1:0] = p ^ c[W-1:0];
    sum[W]     = a[W] ^ (sub ? ~b[W] : b[W]) ^ c[W];
  end

endmodule

// File: rtl/div_nonrestoring.sv
// Iterative radix-2 non-restoring signed divider with one shared add/sub.
// Ready WIDTH+3 edges after start (2 on exception); no backpressure, a new start aborts any op in flight.
module div_nonrestoring
  import div_nonrestoring_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [WIDTH-1:0]     OVF_DIVIDEND = WIDTH'(DIV_OVF_DIVIDEND);
  localparam logic [DIV_CNT_W-1:0] LAST_CNT     = DIV_CNT_W'(WIDTH - 1);

  logic [2:0]           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     a_lat;
  logic [WIDTH-1:0]     b_lat;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     bmag;
  logic [WIDTH:0]       r;
  logic                 q_neg;
  logic                 r_neg;
  logic                 exc_pend;

  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [WIDTH-1:0]     rem_neg;
  logic [WIDTH:0]       r_shift;
  logic                 div_zero;
  logic                 ovf;
  logic [WIDTH:0]       as_a;
  logic [WIDTH:0]       as_b;
  logic                 as_sub;
  logic [WIDTH:0]       as_sum;

  // Magnitudes are unsigned, so |0x80000000| stays 0x80000000.
  assign a_abs    = a_lat[WIDTH-1] ? (~a_lat + WIDTH'(1)) : a_lat;
  assign b_abs    = b_lat[WIDTH-1] ? (~b_lat + WIDTH'(1)) : b_lat;
  assign rem_neg  = ~r[WIDTH-1:0] + WIDTH'(1);
  assign r_shift  = {r[WIDTH-1:0], q[WIDTH-1]};
  assign div_zero = (b_lat == '0);
  assign ovf      = (a_lat == OVF_DIVIDEND) && (&b_lat);

  always_comb begin
    as_a   = r_shift;
    as_b   = {1'b0, bmag};
    as_sub = ~r_shift[WIDTH];
    case (state)
      ST_CORR: begin
        as_a   = r;
        as_sub = 1'b0;
      end
      ST_SIGN: begin
        as_a   = '0;
        as_b   = {1'b0, q};
        as_sub = 1'b1;
      end
      default: ;
    endcase
  end

  div_addsub #(.W(WIDTH)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .sum (as_sum)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      a_lat          <= '0;
      b_lat          <= '0;
      q              <= '0;
      bmag           <= '0;
      r              <= '0;
      q_neg          <= 1'b0;
      r_neg          <= 1'b0;
      exc_pend       <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      a_lat <= data_operandA;
      b_lat <= data_operandB;
      state <= ST_PREP;
    end else begin
      case (state)
        ST_PREP: begin
          r    <= '0;
          cnt  <= '0;
          bmag <= b_abs;
          // Exceptions still pass through SIGN so results are published from one place.
          if (div_zero || ovf) begin
            exc_pend <= 1'b1;
            q        <= div_zero ? '0 : OVF_DIVIDEND;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            state    <= ST_SIGN;
          end else begin
            exc_pend <= 1'b0;
            q        <= a_abs;
            q_neg    <= a_lat[WIDTH-1] ^ b_lat[WIDTH-1];
            r_neg    <= a_lat[WIDTH-1];
            state    <= ST_ITER;
          end
        end
        ST_ITER: begin
          r   <= as_sum;
          q   <= {q[WIDTH-2:0], ~as_sum[WIDTH]};
          cnt <= cnt + DIV_CNT_W'(1);
          if (cnt == LAST_CNT) state <= ST_CORR;
        end
        ST_CORR: begin
          if (r[WIDTH]) r <= as_sum;
          state <= ST_SIGN;
        end
        ST_SIGN: begin
          data_result    <= q_neg ? as_sum[WIDTH-1:0] : q;
          data_remainder <= r_neg ? rem_neg : r[WIDTH-1:0];
          data_exception <= exc_pend;
          state          <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_resultRDY = (state == ST_DONE);
  assign busy           = (state != ST_IDLE) && (state != ST_DONE);

endmodule

// File: tb/tb_div_nonrestoring.sv
// Randomised and directed bench for div_nonrestoring against a plain signed-arithmetic reference.
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
module tb_div_nonrestoring;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  div_nonrestoring dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Reference: C-style truncating signed division with the two exception cases.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic e);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; e = 1'b1;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb); e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'(-$urandom_range(1, 20));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at 1 unit after a rising edge; returns at 1 unit after the ready edge (lat = edges after start).
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output logic [31:0] q, output logic [31:0] r, output logic e);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        lat = k;
        break;
      end
    end
    q = data_result;
    r = data_remainder;
    e = data_exception;
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_DIV = 1'b0; data_operandA = 32'd0; data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (data_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", data_result); end
    n_checks++; if (data_remainder !== 32'd0) begin n_fail++; $display("FAIL reset_remainder: got %h want 0", data_remainder); end
    n_checks++; if ({data_exception, data_resultRDY, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {data_exception, data_resultRDY, busy}); end
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++; if ({data_resultRDY, busy} !== 2'b00) begin n_fail++; $display("FAIL idle_flags: got %b want 00", {data_resultRDY, busy}); end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] q, r; logic e;
    data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin lat = k; break; end
    end
    q = data_result; r = data_remainder; e = data_exception;
    n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL basic_latency: got %0d want 35", lat); end
    n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL basic_quotient: got %0d want 14", q); end
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL basic_remainder: got %0d want 2", r); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_exception: got %b want 0", e); end
    @(posedge clock); #1;
    n_checks++; if ({data_resultRDY, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_pulse_end: got %b want 00", {data_resultRDY, busy}); end
    n_checks++; if (data_result !== 32'd14) begin n_fail++; $display("FAIL basic_hold: got %0d want 14", data_result); end
  endtask

  task automatic test_signs();
    int lat; logic [31:0] q, r; logic e;
    do_div(-32'sd100, 32'd7, lat, q, r, e);
    n_checks++; if (q !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL neg_dividend_q: got %h want fffffff2", q); end
    n_checks++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL neg_dividend_r: got %h want fffffffe", r); end
    do_div(32'd100, -32'sd7, lat, q, r, e);
    n_checks++; if (q !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL neg_divisor_q: got %h want fffffff2", q); end
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL neg_divisor_r: got %h want 2", r); end
    do_div(32'd5, 32'd10, lat, q, r, e);
    n_checks++; if ({q, r} !== {32'd0, 32'd5}) begin n_fail++; $display("FAIL small_over_large: got q=%0d r=%0d want 0 5", q, r); end
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, q, r, e);
    n_checks++; if ({q, r, e} !== {32'd1, 32'd0, 1'b0}) begin n_fail++; $display("FAIL minus1_by_minus1: got q=%h r=%h e=%b want 1 0 0", q, r, e); end
  endtask

  task automatic test_exceptions();
    int lat; logic [31:0] q, r; logic e;
    do_div(32'd7, 32'd0, lat, q, r, e);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL divzero_latency: got %0d want 2", lat); end
    n_checks++; if ({q, r, e} !== {32'd0, 32'd0, 1'b1}) begin n_fail++; $display("FAIL divzero_outputs: got q=%h r=%h e=%b want 0 0 1", q, r, e); end
    do_div(32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, e);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL overflow_latency: got %0d want 2", lat); end
    n_checks++; if ({q, r, e} !== {32'h8000_0000, 32'd0, 1'b1}) begin n_fail++; $display("FAIL overflow_outputs: got q=%h r=%h e=%b want 80000000 0 1", q, r, e); end
    do_div(32'h8000_0000, 32'd1, lat, q, r, e);
    n_checks++; if ({q, r, e} !== {32'h8000_0000, 32'd0, 1'b0}) begin n_fail++; $display("FAIL intmin_by_one: got q=%h r=%h e=%b want 80000000 0 0", q, r, e); end
    n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL intmin_by_one_latency: got %0d want 35", lat); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] a, b, q, r, eq, er; logic e, ee;
    for (int i = 0; i < 60; i++) begin
      a = pick();
      b = pick();
      model(a, b, eq, er, ee);
      do_div(a, b, lat, q, r, e);
      n_checks++;
      if (q !== eq || r !== er || e !== ee || lat !== (ee ? 2 : 35)) begin
        n_fail++;
        $display("FAIL random[%0d] %h/%h: got q=%h r=%h e=%b lat=%0d want q=%h r=%h e=%b lat=%0d",
                 i, a, b, q, r, e, lat, eq, er, ee, (ee ? 2 : 35));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] q, r; logic e;
    do_div(32'd1000, 32'd3, lat, q, r, e);
    n_checks++; if ({q, r} !== {32'd333, 32'd1}) begin n_fail++; $display("FAIL b2b_first: got q=%0d r=%0d want 333 1", q, r); end
    // Strobe lands on the DONE cycle of the previous op.
    do_div(-32'sd50, 32'd5, lat, q, r, e);
    n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL b2b_latency: got %0d want 35", lat); end
    n_checks++; if ({q, r, e} !== {32'hFFFF_FFF6, 32'd0, 1'b0}) begin n_fail++; $display("FAIL b2b_second: got q=%h r=%h e=%b want fffffff6 0 0", q, r, e); end
  endtask

  task automatic test_abort();
    int pulses = 0;
    int first  = -1;
    data_operandA = 32'd1000; data_operandB = 32'd3; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) pulses++;
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %b want 1", busy); end
    data_operandA = 32'd50; data_operandB = 32'd5; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0; data_operandA = 32'd9; data_operandB = 32'd0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL abort_pulse_count: got %0d want 1", pulses); end
    n_checks++; if (first !== 35) begin n_fail++; $display("FAIL abort_latency: got %0d want 35", first); end
    n_checks++; if ({data_result, data_remainder, data_exception} !== {32'd10, 32'd0, 1'b0}) begin n_fail++; $display("FAIL abort_result: got q=%0d r=%0d e=%b want 10 0 0", data_result, data_remainder, data_exception); end
  endtask

  task automatic test_reset_mid_op();
    int pulses = 0;
    data_operandA = 32'd1000; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if ({data_result, data_remainder} !== 64'd0) begin n_fail++; $display("FAIL midreset_data: got q=%h r=%h want 0 0", data_result, data_remainder); end
    n_checks++; if ({data_exception, data_resultRDY, busy} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags: got %b want 000", {data_exception, data_resultRDY, busy}); end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midreset_no_ready: got %0d pulses want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_exceptions();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
